// File: rtl/master_fsm_multitrack_pkg.sv
// Shared state codes, default key indices and sizing helper for the multitrack
// piano controller.
package master_fsm_multitrack_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StStart    = 3'd0,
        StRecord   = 3'd1,
        StPlayback = 3'd2,
        StRestart  = 3'd3,
        StPause    = 3'd4,
        StDone     = 3'd5
    } stateE;

    localparam int unsigned DEF_NUM_KEYS   = 30;
    localparam int unsigned DEF_NUM_TRACKS = 4;
    localparam int unsigned DEF_TIME_W     = 16;
    localparam int unsigned DEF_KEY_SPACE  = 28;
    localparam int unsigned DEF_KEY_R      = 18;
    localparam int unsigned DEF_KEY_P      = 24;
    localparam int unsigned DEF_KEY_L      = 23;
    localparam int unsigned DEF_KEY_BKSP   = 13;
    localparam int unsigned DEF_KEY_TRK0   = 1;

    // A single track still needs a 1-bit select so port widths never collapse to zero.
    function automatic int unsigned trackIdxWidth(int unsigned numTracks);
        return (numTracks > 1) ? $clog2(numTracks) : 1;
    endfunction

endpackage

// File: rtl/master_fsm_multitrack_if.sv
// Keyboard-in / control-out bundle between the master FSM and the storage,
// audio and VGA consumers.
interface master_fsm_multitrack_if
    import master_fsm_multitrack_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = DEF_NUM_KEYS,
    parameter int unsigned NUM_TRACKS = DEF_NUM_TRACKS,
    parameter int unsigned TIME_W     = DEF_TIME_W
) ();

    localparam int unsigned TRK_W = trackIdxWidth(NUM_TRACKS);

    logic [NUM_KEYS-1:0]   inputStateStorage;
    logic                  tick;
    logic [STATE_W-1:0]    currentState;
    logic                  timerEnable;
    logic [TIME_W-1:0]     playTime;
    logic [TRK_W-1:0]      recordTrack;
    logic [NUM_TRACKS-1:0] recordEnable;
    logic [NUM_TRACKS-1:0] trackValid;
    logic                  loopMode;

    modport master (
        input  inputStateStorage,
        input  tick,
        output currentState,
        output timerEnable,
        output playTime,
        output recordTrack,
        output recordEnable,
        output trackValid,
        output loopMode
    );

    modport slave (
        output inputStateStorage,
        output tick,
        input  currentState,
        input  timerEnable,
        input  playTime,
        input  recordTrack,
        input  recordEnable,
        input  trackValid,
        input  loopMode
    );

endinterface

// File: rtl/master_fsm_multitrack_key_edge_detect.sv
// Rising-edge detector for level key states; the history register resets to
// ones so keys already held during reset never produce an edge.
module key_edge_detect #(
    parameter int unsigned WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] keys,
    output logic [WIDTH-1:0] keyEdge
);

    logic [WIDTH-1:0] prevQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevQ <= '1;
        end else begin
            prevQ <= keys;
        end
    end

    assign keyEdge = keys & ~prevQ;

endmodule

// File: rtl/master_fsm_multitrack.sv
// Top-level piano control FSM: multitrack record/playback with pause, loop,
// restart and per-track clear, driven by key edges and an external tick.
module master_fsm_multitrack
    import master_fsm_multitrack_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = DEF_NUM_KEYS,
    parameter int unsigned NUM_TRACKS = DEF_NUM_TRACKS,
    parameter int unsigned TIME_W     = DEF_TIME_W,
    parameter int unsigned KEY_SPACE  = DEF_KEY_SPACE,
    parameter int unsigned KEY_R      = DEF_KEY_R,
    parameter int unsigned KEY_P      = DEF_KEY_P,
    parameter int unsigned KEY_L      = DEF_KEY_L,
    parameter int unsigned KEY_BKSP   = DEF_KEY_BKSP,
    parameter int unsigned KEY_TRK0   = DEF_KEY_TRK0
) (
    input logic                     clk,
    input logic                     reset,
    master_fsm_multitrack_if.master bus
);

    localparam int unsigned TRK_W = trackIdxWidth(NUM_TRACKS);

    logic [NUM_KEYS-1:0] keyEdge;
    logic                edgeSpace;
    logic                edgeR;
    logic                edgeP;
    logic                edgeL;
    logic                edgeBksp;
    logic                unusedEdges;
    logic [NUM_TRACKS-1:0] trkEdge;

    key_edge_detect #(
        .WIDTH (NUM_KEYS)
    ) uKeyEdge (
        .clk     (clk),
        .reset   (reset),
        .keys    (bus.inputStateStorage),
        .keyEdge (keyEdge)
    );

    assign edgeSpace   = keyEdge[KEY_SPACE];
    assign edgeR       = keyEdge[KEY_R];
    assign edgeP       = keyEdge[KEY_P];
    assign edgeL       = keyEdge[KEY_L];
    assign edgeBksp    = keyEdge[KEY_BKSP];
    assign unusedEdges = ^keyEdge;

    for (genvar t = 0; t < NUM_TRACKS; t++) begin : gTrkEdge
        assign trkEdge[t] = keyEdge[KEY_TRK0 + t];
    end

    stateE                              stateQ, stateD;
    logic [TIME_W-1:0]                  playTimeQ, playTimeD;
    logic [TRK_W-1:0]                   recordTrackQ, recordTrackD;
    logic [NUM_TRACKS-1:0]              trackValidQ, trackValidD;
    logic [NUM_TRACKS-1:0][TIME_W-1:0]  lengthQ, lengthD;
    logic                               loopModeQ, loopModeD;

    logic [NUM_TRACKS-1:0] selOneHot;
    logic [TIME_W-1:0]     playLength;
    logic [TIME_W:0]       nextPos;
    logic                  atEnd;
    logic                  timeSat;
    logic                  recStop;

    always_comb begin
        selOneHot = '0;
        for (int t = 0; t < int'(NUM_TRACKS); t++) begin
            selOneHot[t] = (recordTrackQ == TRK_W'(t));
        end
    end

    // Playback runs to the longest valid track.
    always_comb begin
        playLength = '0;
        for (int t = 0; t < int'(NUM_TRACKS); t++) begin
            if (trackValidQ[t] && (lengthQ[t] > playLength)) begin
                playLength = lengthQ[t];
            end
        end
    end

    // One bit wider so the end compare cannot wrap at full scale.
    assign nextPos = {1'b0, playTimeQ} + (TIME_W + 1)'(1);
    assign atEnd   = (nextPos >= {1'b0, playLength});
    assign timeSat = &playTimeQ;
    assign recStop = edgeSpace || (bus.tick && timeSat);

    always_comb begin
        stateD       = stateQ;
        playTimeD    = playTimeQ;
        recordTrackD = recordTrackQ;
        trackValidD  = trackValidQ;
        lengthD      = lengthQ;
        loopModeD    = loopModeQ ^ edgeL;

        if (stateQ != StRecord) begin
            // Walk downwards so the lowest simultaneous select wins.
            for (int t = int'(NUM_TRACKS) - 1; t >= 0; t--) begin
                if (trkEdge[t]) begin
                    recordTrackD = TRK_W'(t);
                end
            end
            if (edgeBksp) begin
                trackValidD = trackValidQ & ~selOneHot;
                for (int t = 0; t < int'(NUM_TRACKS); t++) begin
                    if (selOneHot[t]) begin
                        lengthD[t] = '0;
                    end
                end
            end
        end

        unique case (stateQ)
            StStart: begin
                if (edgeSpace) begin
                    stateD    = StRecord;
                    playTimeD = '0;
                end
            end

            StRecord: begin
                if (recStop) begin
                    if (playTimeQ != '0) begin
                        trackValidD = trackValidQ | selOneHot;
                        for (int t = 0; t < int'(NUM_TRACKS); t++) begin
                            if (selOneHot[t]) begin
                                lengthD[t] = playTimeQ;
                            end
                        end
                    end
                    playTimeD = '0;
                    stateD    = (trackValidD != '0) ? StPlayback : StStart;
                end else if (bus.tick) begin
                    playTimeD = nextPos[TIME_W-1:0];
                end
            end

            StPlayback: begin
                if (edgeR) begin
                    stateD    = StRestart;
                    playTimeD = '0;
                end else if (edgeSpace) begin
                    stateD    = StRecord;
                    playTimeD = '0;
                end else if (edgeP) begin
                    stateD = StPause;
                end else if (bus.tick) begin
                    if (atEnd) begin
                        if (loopModeQ) begin
                            stateD    = StRestart;
                            playTimeD = '0;
                        end else begin
                            stateD = StDone;
                        end
                    end else begin
                        playTimeD = nextPos[TIME_W-1:0];
                    end
                end
            end

            StRestart: begin
                stateD    = StPlayback;
                playTimeD = '0;
            end

            StPause: begin
                if (edgeP) begin
                    stateD = StPlayback;
                end else if (edgeR) begin
                    stateD    = StRestart;
                    playTimeD = '0;
                end else if (edgeSpace) begin
                    stateD    = StRecord;
                    playTimeD = '0;
                end
            end

            StDone: begin
                if (edgeR) begin
                    stateD    = StRestart;
                    playTimeD = '0;
                end else if (edgeSpace) begin
                    stateD    = StRecord;
                    playTimeD = '0;
                end
            end

            default: begin
                stateD    = StStart;
                playTimeD = '0;
            end
        endcase

        // Clearing the last recording leaves nothing to play.
        if (edgeBksp && (trackValidD == '0) &&
            (stateQ inside {StPlayback, StPause, StDone})) begin
            stateD    = StStart;
            playTimeD = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ       <= StStart;
            playTimeQ    <= '0;
            recordTrackQ <= '0;
            trackValidQ  <= '0;
            lengthQ      <= '0;
            loopModeQ    <= 1'b0;
        end else begin
            stateQ       <= stateD;
            playTimeQ    <= playTimeD;
            recordTrackQ <= recordTrackD;
            trackValidQ  <= trackValidD;
            lengthQ      <= lengthD;
            loopModeQ    <= loopModeD;
        end
    end

    assign bus.currentState = stateQ;
    assign bus.timerEnable  = (stateQ == StRecord) || (stateQ == StPlayback);
    assign bus.playTime     = playTimeQ;
    assign bus.recordTrack  = recordTrackQ;
    assign bus.recordEnable = (stateQ == StRecord) ? selOneHot : '0;
    assign bus.trackValid   = trackValidQ;
    assign bus.loopMode     = loopModeQ;

endmodule
